// File: rtl/ram_sched_pkg.sv
// Shared types and default sizes for the RAM write scheduler.
package ram_sched_pkg;

   localparam int NREQ_DEF = 3;
   localparam int AW_DEF   = 8;
   localparam int DW_DEF   = 8;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WRITE,
      S_READ,
      S_CHECK,
      S_ACK
   } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first asserted request at or above ptr, wrapping.
module rr_arbiter #(
   parameter int NREQ = 3,
   parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic [NREQ-1:0] req,
   input  logic [IW-1:0]   ptr,
   output logic [NREQ-1:0] grant,
   output logic [IW-1:0]   winner,
   output logic            any
);

   always_comb begin
      int i;
      grant  = '0;
      winner = '0;
      any    = 1'b0;
      i      = 0;
      for (int k = 0; k < NREQ; k++) begin
         i = (int'(ptr) + k) % NREQ;
         if (!any && req[i]) begin
            any      = 1'b1;
            grant[i] = 1'b1;
            winner   = IW'(i);
         end
      end
   end

endmodule

// File: rtl/ram_write_scheduler.sv
// Round-robin RAM write scheduler; define RAM_WSCHED_VERIFY_EN to add
// a readback check (READ/CHECK) between the write and its ack.
module ram_write_scheduler
   import ram_sched_pkg::*;
#(
   parameter int NREQ = NREQ_DEF,
   parameter int AW   = AW_DEF,
   parameter int DW   = DW_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [NREQ-1:0]  req,
   input  logic [NREQ*AW-1:0] req_addr,
   input  logic [NREQ*DW-1:0] req_data,
   output logic [NREQ-1:0]  ack,
   output logic             mem_we,
   output logic [AW-1:0]    mem_addr,
   output logic [DW-1:0]    mem_wdata,
   input  logic [DW-1:0]    mem_rdata,
   output logic             busy,
   output logic             err
);

   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

   state_e          state_q, state_d;
   logic [IW-1:0]   ptr_q, ptr_d;
   logic [IW-1:0]   win_q, win_d;
   logic [AW-1:0]   addr_q, addr_d;
   logic [DW-1:0]   data_q, data_d;
   logic [NREQ-1:0] gnt_unused;
   logic [IW-1:0]   winner;
   logic            any;

   rr_arbiter #(
      .NREQ (NREQ),
      .IW   (IW)
   ) u_arb (
      .req    (req),
      .ptr    (ptr_q),
      .grant  (gnt_unused),
      .winner (winner),
      .any    (any)
   );

`ifdef RAM_WSCHED_VERIFY_EN
   logic err_q, err_d;
`endif

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      win_d   = win_q;
      addr_d  = addr_q;
      data_d  = data_q;
`ifdef RAM_WSCHED_VERIFY_EN
      err_d   = err_q;
`endif
      unique case (state_q)
         S_IDLE: begin
            if (any) begin
               state_d = S_WRITE;
               win_d   = winner;
               addr_d  = req_addr[int'(winner)*AW +: AW];
               data_d  = req_data[int'(winner)*DW +: DW];
               ptr_d   = (winner == IW'(NREQ-1)) ? '0
                                                 : IW'(winner + 1'b1);
            end
         end
`ifdef RAM_WSCHED_VERIFY_EN
         S_WRITE: state_d = S_READ;
         S_READ:  state_d = S_CHECK;
         S_CHECK: begin
            // Sync-read data for the READ-cycle address lands here
            if (mem_rdata != data_q) err_d = 1'b1;
            state_d = S_ACK;
         end
`else
         S_WRITE: state_d = S_ACK;
`endif
         S_ACK:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         ptr_q   <= '0;
         win_q   <= '0;
         addr_q  <= '0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         win_q   <= win_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
      end
   end

`ifdef RAM_WSCHED_VERIFY_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) err_q <= 1'b0;
      else        err_q <= err_d;
   end
   assign err = err_q;
`else
   logic unused_rdata;
   assign unused_rdata = ^mem_rdata;
   assign err = 1'b0;
`endif

   // Outputs decode straight from state so reset kills them at once
   assign mem_we    = (state_q == S_WRITE);
   assign busy      = (state_q != S_IDLE);
   assign mem_addr  = addr_q;
   assign mem_wdata = data_q;

   always_comb begin
      ack = '0;
      if (state_q == S_ACK) ack[win_q] = 1'b1;
   end

endmodule

// File: tb/tb_ram_write_scheduler.sv
// Scoreboard bench: round-robin service order predicted from the
// arbitration rule, checked by a monitor on every write and ack.
module tb_ram_write_scheduler;

   localparam int N  = 3;
   localparam int AW = 8;
   localparam int DW = 8;
`ifdef RAM_WSCHED_VERIFY_EN
   localparam int LAT = 3;
`else
   localparam int LAT = 1;
`endif

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic [N-1:0]    req = '0;
   logic [N*AW-1:0] req_addr = '0;
   logic [N*DW-1:0] req_data = '0;
   logic [N-1:0]    ack;
   logic            mem_we;
   logic [AW-1:0]   mem_addr;
   logic [DW-1:0]   mem_wdata;
   logic [DW-1:0]   mem_rdata;
   logic            busy;
   logic            err;

   ram_write_scheduler #(.NREQ(N), .AW(AW), .DW(DW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .req_addr  (req_addr),
      .req_data  (req_data),
      .ack       (ack),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .busy      (busy),
      .err       (err)
   );

   always #5 clk = ~clk;

   logic [DW-1:0] ram [256];
   bit corrupt = 1'b0;

   always @(posedge clk) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      mem_rdata <= corrupt ? ram[mem_addr] - 1'b1 : ram[mem_addr];
   end

   typedef struct {
      int            id;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
   } exp_t;

   exp_t q[$];
   exp_t cur;
   int   checks = 0;
   int   errors = 0;
   int   mptr = 0;
   bit   ack_pend = 1'b0;
   int   cyc = 0;
   int   we_cyc = 0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Monitor: every write and every ack must match the queue head
   always @(negedge clk) begin
      cyc++;
      if (!rst_n) begin
         ack_pend = 1'b0;
      end else begin
         if (mem_we) begin
            chk("write_expected", 32'(q.size() != 0), 1);
            if (q.size() != 0) begin
               cur = q.pop_front();
               chk("mem_addr", mem_addr, cur.a);
               chk("mem_wdata", mem_wdata, cur.d);
               chk("busy_on_write", busy, 1);
               ack_pend = 1'b1;
               we_cyc = cyc;
            end
         end
         if (ack != '0) begin
            chk("ack_expected", ack_pend, 1);
            chk("ack_onehot", ack, 32'(1) << cur.id);
            chk("ack_latency", cyc - we_cyc, LAT);
            ack_pend = 1'b0;
         end
      end
   end

   task automatic issue(input logic [N-1:0] m);
      for (int i = 0; i < N; i++) begin
         if (m[i]) begin
            req_addr[i*AW +: AW] = AW'($urandom);
            req_data[i*DW +: DW] = DW'($urandom);
         end
      end
      req = req | m;
   endtask

   // Service order: repeatedly first pending at/above ptr, ptr=win+1
   task automatic predict(input logic [N-1:0] m);
      logic [N-1:0] pend;
      exp_t e;
      pend = m;
      while (pend != '0) begin
         for (int k = 0; k < N; k++) begin
            int i;
            i = (mptr + k) % N;
            if (pend[i]) begin
               e.id = i;
               e.a  = req_addr[i*AW +: AW];
               e.d  = req_data[i*DW +: DW];
               q.push_back(e);
               pend[i] = 1'b0;
               mptr = (i + 1) % N;
               break;
            end
         end
      end
   endtask

   task automatic drain();
      int t;
      t = 0;
      while ((req != '0 || q.size() != 0 || ack_pend || busy) && t < 200) begin
         @(posedge clk);
         #2;
         req = req & ~ack;
         t++;
      end
      chk("drain_in_time", 32'(t < 200), 1);
   endtask

   task automatic check_reset_vals();
      chk("rst_ack", ack, 0);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      chk("rst_busy", busy, 0);
      chk("rst_err", err, 0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      req = '0;
      mptr = 0;
      q.delete();
      #2;
      check_reset_vals();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [N-1:0] m;
      for (int i = 0; i < 256; i++) ram[i] = '0;
      #12;
      check_reset_vals();
      @(negedge clk);
      rst_n = 1'b1;

      // Single request, absolute timing
      @(negedge clk);
      req_addr[1*AW +: AW] = 8'd6;
      req_data[1*DW +: DW] = 8'd9;
      req = 3'b010;
      predict(3'b010);
      @(posedge clk);
      #1;
      chk("t1_we", mem_we, 1);
      chk("t1_addr", mem_addr, 6);
      chk("t1_data", mem_wdata, 9);
      chk("t1_busy", busy, 1);
      repeat (LAT) @(posedge clk);
      #1;
      chk("t2_ack", ack, 3'b010);
      chk("t2_busy", busy, 1);
      chk("t2_we", mem_we, 0);
      req = '0;
      @(posedge clk);
      #1;
      chk("t3_busy", busy, 0);
      chk("t3_ack", ack, 0);
      drain();

      // Two held requests from ptr=0
      do_reset();
      issue(3'b101);
      predict(3'b101);
      drain();

      // All held: 0,1,2 then wrap 0,1,2
      do_reset();
      issue(3'b111);
      predict(3'b111);
      drain();
      issue(3'b111);
      predict(3'b111);
      drain();

      // Drop req and change addr after grant
      issue(3'b001);
      predict(3'b001);
      @(posedge clk);
      @(negedge clk);
      req[0] = 1'b0;
      req_addr[0 +: AW] = 8'd5;
      drain();

      // Reset during WRITE, then pending requests resume from ptr=0
      do_reset();
      issue(3'b010);
      @(posedge clk);
      #1;
      chk("pre_rst_we", mem_we, 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_we", mem_we, 0);
      chk("mid_rst_ack", ack, 0);
      chk("mid_rst_busy", busy, 0);
      issue(3'b100);
      @(negedge clk);
      rst_n = 1'b1;
      mptr = 0;
      predict(3'b110);
      drain();

      // Random batches
      repeat (40) begin
         m = N'($urandom_range(1, (1 << N) - 1));
         issue(m);
         predict(m);
         drain();
      end
      chk("err_clean", err, 0);

`ifdef RAM_WSCHED_VERIFY_EN
      do_reset();
      corrupt = 1'b1;
      req_addr[0 +: AW] = 8'd0;
      req_data[0 +: DW] = 8'd9;
      req = 3'b001;
      predict(3'b001);
      drain();
      corrupt = 1'b0;
      chk("err_set", err, 1);
      repeat (5) @(posedge clk);
      #1;
      chk("err_sticky", err, 1);
      do_reset();
      chk("err_cleared", err, 0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ram_write_scheduler.md
RAM_WRITE_SCHEDULER -- requirements
Module: ram_write_scheduler

Interface
REQ-001 Parameter NREQ, default 3, SHALL set the number of write requesters (2..8).
REQ-002 Parameter AW, default 8, SHALL set the RAM address width.
REQ-003 Parameter DW, default 8, SHALL set the RAM data width.
REQ-004 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 rst_n  in  1  SHALL be the asynchronous, active-low reset.
REQ-006 req  in  NREQ  SHALL carry per-requester write requests, held high until ack.
REQ-007 req_addr  in  NREQ*AW  SHALL carry per-requester addresses, slice i = requester i.
REQ-008 req_data  in  NREQ*DW  SHALL carry per-requester write data, slice i = requester i.
REQ-009 ack  out  NREQ  SHALL pulse one cycle on the bit of the requester whose write completed.
REQ-010 mem_we  out  1  SHALL be the RAM write enable.
REQ-011 mem_addr  out  AW  SHALL be the RAM address.
REQ-012 mem_wdata  out  DW  SHALL be the RAM write data.
REQ-013 mem_rdata  in  DW  SHALL be the RAM read data, valid one cycle after address (synchronous read).
REQ-014 busy  out  1  SHALL be high whenever the FSM is not in IDLE.
REQ-015 err  out  1  SHALL be the sticky readback-mismatch flag.

Function
REQ-016 FSM states SHALL be IDLE, WRITE, ACK, plus READ and CHECK when RAM_WSCHED_VERIFY_EN is defined.
REQ-017 IDLE with any req bit high at a rising edge SHALL latch winner index, its addr and data, and go to WRITE.
REQ-018 Winner SHALL be chosen round-robin: first asserted req at or above pointer ptr, wrapping modulo NREQ.
REQ-019 ptr SHALL update to (winner+1) mod NREQ on each grant; NREQ-1 wraps to 0.
REQ-020 WRITE SHALL drive mem_we=1 with latched addr/data for exactly one cycle, then go to ACK (or READ when verify enabled).
REQ-021 ACK SHALL assert ack[winner] for exactly one cycle, then return to IDLE.
REQ-022 Without verify, latency SHALL be: req sampled edge 0 -> mem_we cycle 1 -> ack cycle 2 -> IDLE cycle 3; max one write per 3 cycles.
REQ-023 mem_addr/mem_wdata SHALL hold latched values in all non-IDLE states; mem_we SHALL be 0 outside WRITE.
REQ-024 A req dropped after grant SHALL NOT abort the transaction; ack still pulses.
REQ-025 A req still high in the cycle after its ack SHALL be treated as a new request.
REQ-026 Changes to req_addr/req_data after grant SHALL NOT affect the latched transaction.
REQ-027 Simultaneous requests SHALL be served one at a time, none dropped, each acked exactly once.

Reset
REQ-028 rst_n low SHALL immediately force state IDLE, ptr=0, ack=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, err=0.
REQ-029 Reset asserted mid-transaction SHALL abort it with no ack; mem_we SHALL drop without waiting for a clock edge.

Configuration
REQ-030 Macro RAM_WSCHED_VERIFY_EN defined SHALL insert READ (mem_we=0, addr held) and CHECK (compare mem_rdata to latched data) between WRITE and ACK.
REQ-031 On CHECK mismatch err SHALL set and stay set until reset; ack SHALL still pulse.
REQ-032 Macro undefined SHALL omit READ/CHECK, tie err to 0, and leave mem_rdata unused.

Structure
REQ-033 Shared package ram_sched_pkg SHALL hold the state enum type and default AW/DW/NREQ constants.
REQ-034 Round-robin selection SHALL live in sub-module rr_arbiter (inputs req, ptr; outputs one-hot grant, winner index, any).

Verification
REQ-035 req=3'b010, addr1=6, data1=9 -> mem_we cycle 1 with addr 6/data 9, ack=3'b010 cycle 2, busy high cycles 1-2.
REQ-036 req=3'b101 held, ptr=0 -> requester 0 written first, then requester 2; ack=001 then 100 with 3 cycles between them.
REQ-037 All three req held continuously -> grant order 0,1,2,0 by ptr wrap; no requester starved.
REQ-038 rst_n low during WRITE -> mem_we low immediately, no ack; after release ptr=0 and a pending req1 is served normally.
REQ-039 Verify enabled, RAM model returns 8 for write of 9 at addr 0 -> err=1 after CHECK, ack still pulses, err persists until reset.
REQ-040 req0 dropped the cycle after grant, addr0 changed to 5 -> write still goes to original address, ack[0] pulses.
